// File: rtl/vector_wb_arbiter.sv
// vector_wb_arbiter: round-robin writeback arbiter between pixel-ALU and multiplier result lanes
module vector_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_valid,
  input  logic [31:0] pxl_d1,
  input  logic [31:0] pxl_d2,
  input  logic [31:0] pxl_d3,
  input  logic [31:0] pxl_d4,
  output logic        pxl_ready,
  input  logic        mul_valid,
  input  logic [31:0] mul_d1,
  input  logic [31:0] mul_d2,
  input  logic [31:0] mul_d3,
  input  logic [31:0] mul_d4,
  output logic        mul_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        we_pxl,
  output logic        wr_pos_pxl,
  output logic [31:0] wdp1,
  output logic [31:0] wdp2,
  output logic [31:0] wdp3,
  output logic [31:0] wdp4,
  output logic        we_mul,
  output logic        wr_mul_pos,
  output logic [31:0] wdm1,
  output logic [31:0] wdm2,
  output logic [31:0] wdm3,
  output logic [31:0] wdm4,
  output logic        mul_pair_done,
  output logic [7:0]  mul_pairs
);
  logic pos_pxl, pos_mul, rr_last, grant_mul, grant_pxl, acc_p, acc_m;
  // rr_last: 0 = pixel granted last, 1 = multiplier granted last
  always_comb begin
    grant_mul = mul_valid & (!pxl_valid | !rr_last);
    grant_pxl = pxl_valid & !grant_mul;
    pxl_ready = grant_pxl & !stall & !flush & !rst;
    mul_ready = grant_mul & !stall & !flush & !rst;
    acc_p     = pxl_valid & pxl_ready;
    acc_m     = mul_valid & mul_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_pxl        <= 1'b0;
      we_mul        <= 1'b0;
      wr_pos_pxl    <= 1'b0;
      wr_mul_pos    <= 1'b0;
      mul_pair_done <= 1'b0;
      mul_pairs     <= 8'd0;
      {wdp1, wdp2, wdp3, wdp4} <= '0;
      {wdm1, wdm2, wdm3, wdm4} <= '0;
      pos_pxl       <= 1'b0;
      pos_mul       <= 1'b0;
      rr_last       <= 1'b0;
    end else begin
      we_pxl        <= acc_p;
      we_mul        <= acc_m;
      mul_pair_done <= acc_m & pos_mul;
      mul_pairs     <= mul_pairs + {7'd0, acc_m & pos_mul};
      if (acc_p) begin
        wr_pos_pxl <= pos_pxl;
        {wdp1, wdp2, wdp3, wdp4} <= {pxl_d1, pxl_d2, pxl_d3, pxl_d4};
      end
      if (acc_m) begin
        wr_mul_pos <= pos_mul;
        {wdm1, wdm2, wdm3, wdm4} <= {mul_d1, mul_d2, mul_d3, mul_d4};
      end
      if (flush) begin
        pos_pxl <= 1'b0;
        pos_mul <= 1'b0;
        rr_last <= 1'b0;
      end else if (acc_p) begin
        pos_pxl <= !pos_pxl;
        rr_last <= 1'b0;
      end else if (acc_m) begin
        pos_mul <= !pos_mul;
        rr_last <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vector_wb_arbiter.sv
// tb_vector_wb_arbiter: directed self-checking bench for vector_wb_arbiter
module tb_vector_wb_arbiter;
  logic clk = 0, rst = 1;
  logic pxl_valid = 0, mul_valid = 0, stall = 0, flush = 0;
  logic [31:0] pxl_d1 = 0, pxl_d2 = 0, pxl_d3 = 0, pxl_d4 = 0;
  logic [31:0] mul_d1 = 0, mul_d2 = 0, mul_d3 = 0, mul_d4 = 0;
  logic pxl_ready, mul_ready, we_pxl, wr_pos_pxl, we_mul, wr_mul_pos, mul_pair_done;
  logic [31:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic [7:0] mul_pairs;
  int errors = 0, checks = 0, dones = 0;
  always #5 clk = ~clk;
  vector_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pxl_valid(pxl_valid), .pxl_d1(pxl_d1), .pxl_d2(pxl_d2), .pxl_d3(pxl_d3), .pxl_d4(pxl_d4),
    .pxl_ready(pxl_ready),
    .mul_valid(mul_valid), .mul_d1(mul_d1), .mul_d2(mul_d2), .mul_d3(mul_d3), .mul_d4(mul_d4),
    .mul_ready(mul_ready), .stall(stall), .flush(flush),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl), .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .we_mul(we_mul), .wr_mul_pos(wr_mul_pos), .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .mul_pair_done(mul_pair_done), .mul_pairs(mul_pairs)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_mul(input logic [31:0] a, b, c, d);
    {mul_d1, mul_d2, mul_d3, mul_d4} = {a, b, c, d};
  endtask
  initial begin
    mul_valid = 1;
    #3;
    chk("rst_mul_ready", {31'd0, mul_ready}, 0);
    chk("rst_outs", {we_pxl, we_mul, wr_pos_pxl, wr_mul_pos, mul_pair_done, mul_pairs}, 0);
    chk("rst_wdm1", wdm1, 0);
    mul_valid = 0;
    tick;
    rst = 0;
    mul_valid = 1;
    set_mul(15, 16, 17, 18);
    #1;
    chk("single_ready", {31'd0, mul_ready}, 1);
    tick;
    chk("single_we0", {31'd0, we_mul}, 1);
    chk("single_pos0", {31'd0, wr_mul_pos}, 0);
    chk("single_d0", {wdm1[7:0], wdm2[7:0], wdm3[7:0], wdm4[7:0]}, {8'd15, 8'd16, 8'd17, 8'd18});
    chk("single_done0", {31'd0, mul_pair_done}, 0);
    set_mul(150, 160, 170, 180);
    tick;
    chk("single_we1", {31'd0, we_mul}, 1);
    chk("single_pos1", {31'd0, wr_mul_pos}, 1);
    chk("single_d1", {wdm1[7:0], wdm2[7:0], wdm3[7:0], wdm4[7:0]}, {8'd150, 8'd160, 8'd170, 8'd180});
    chk("single_done1", {31'd0, mul_pair_done}, 1);
    chk("single_pairs", {24'd0, mul_pairs}, 1);
    mul_valid = 0;
    tick;
    chk("single_we_off", {31'd0, we_mul}, 0);
    chk("single_hold", wdm4, 180);
    rst = 1;
    #1;
    rst = 0;
    chk("rerst_pairs", {24'd0, mul_pairs}, 0);
    pxl_valid = 1;
    mul_valid = 1;
    {pxl_d1, pxl_d2, pxl_d3, pxl_d4} = {32'd101, 32'd102, 32'd103, 32'd104};
    set_mul(201, 202, 203, 204);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_mul_ready%0d", i), {31'd0, mul_ready}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_pxl_ready%0d", i), {31'd0, pxl_ready}, (i % 2 == 1) ? 1 : 0);
      tick;
      chk($sformatf("cont_we%0d", i), {30'd0, we_mul, we_pxl}, (i % 2 == 0) ? 2 : 1);
      if (i % 2 == 1) chk($sformatf("cont_pxl_pos%0d", i), {31'd0, wr_pos_pxl}, (i == 3) ? 1 : 0);
      else chk($sformatf("cont_mul_pos%0d", i), {31'd0, wr_mul_pos}, (i == 2) ? 1 : 0);
    end
    chk("cont_pairs", {24'd0, mul_pairs}, 1);
    chk("cont_wdp1", wdp1, 101);
    pxl_valid = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready%0d", i), {31'd0, mul_ready}, 0);
      tick;
      chk($sformatf("stall_we%0d", i), {31'd0, we_mul}, 0);
    end
    stall = 0;
    #1;
    chk("unstall_ready", {31'd0, mul_ready}, 1);
    tick;
    chk("unstall_we", {31'd0, we_mul}, 1);
    chk("unstall_pos", {31'd0, wr_mul_pos}, 0);
    mul_valid = 0;
    pxl_valid = 1;
    tick;
    chk("flush_pre_we", {31'd0, we_pxl}, 1);
    chk("flush_pre_pos", {31'd0, wr_pos_pxl}, 0);
    flush = 1;
    #1;
    chk("flush_ready", {31'd0, pxl_ready}, 0);
    tick;
    chk("flush_we", {31'd0, we_pxl}, 0);
    flush = 0;
    tick;
    chk("postflush_we", {31'd0, we_pxl}, 1);
    chk("postflush_pos", {31'd0, wr_pos_pxl}, 0);
    chk("flush_pairs_hold", {24'd0, mul_pairs}, 1);
    pxl_valid = 0;
    rst = 1;
    #1;
    rst = 0;
    mul_valid = 1;
    for (int i = 0; i < 512; i++) begin
      tick;
      if (we_mul && mul_pair_done) dones++;
      if (i == 509) chk("wrap_255", {24'd0, mul_pairs}, 255);
    end
    mul_valid = 0;
    chk("wrap_pairs", {24'd0, mul_pairs}, 0);
    chk("wrap_dones", dones, 256);
    mul_valid = 1;
    set_mul(7, 8, 9, 10);
    tick;
    chk("arst_pre_we", {31'd0, we_mul}, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_outs", {we_pxl, we_mul, wr_pos_pxl, wr_mul_pos, mul_pair_done, mul_pairs}, 0);
    chk("arst_wdm1", wdm1, 0);
    chk("arst_ready", {30'd0, mul_ready, pxl_ready}, 0);
    mul_valid = 0;
    #1;
    rst = 0;
    tick;
    chk("arst_post_we0", {30'd0, we_mul, we_pxl}, 0);
    tick;
    chk("arst_post_we1", {30'd0, we_mul, we_pxl}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_wb_arbiter.md
VECTOR_WB_ARBITER -- requirements
Module: vector_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-002 The block SHALL have ports pxl_valid in 1 (pixel-ALU result valid) and pxl_d1..pxl_d4 in 32 each (pixel lane data).
REQ-003 The block SHALL have port pxl_ready out 1 (pixel result accepted this cycle).
REQ-004 The block SHALL have ports mul_valid in 1 (multiplier result valid) and mul_d1..mul_d4 in 32 each (multiplier lane data).
REQ-005 The block SHALL have port mul_ready out 1 (multiplier result accepted this cycle).
REQ-006 The block SHALL have ports stall in 1 (pipeline hold) and flush in 1 (synchronous clear of sequencing state).
REQ-007 The block SHALL have ports we_pxl out 1, wr_pos_pxl out 1, wdp1..wdp4 out 32 each: pixel register bank write strobe, position and data.
REQ-008 The block SHALL have ports we_mul out 1, wr_mul_pos out 1, wdm1..wdm4 out 32 each: multiplier register bank write strobe, position and data.
REQ-009 The block SHALL have ports mul_pair_done out 1 (both mul positions written) and mul_pairs out 8 (completed pair count).

Function
REQ-010 Shared resource: one 4x32 writeback data register; at most one bank write SHALL occur per cycle.
REQ-011 Grant, combinational: with one requester valid, that requester is granted; with both valid, the requester not granted last (rr_last) is granted.
REQ-012 pxl_ready = grant_pxl & !stall & !flush; mul_ready = grant_mul & !stall & !flush; ready never depends on ready.
REQ-013 Transfer occurs on valid & ready; a requester SHALL hold valid and data stable until ready.
REQ-014 Latency 1: data accepted in cycle N appears on wdpX or wdmX in cycle N+1 with the matching we_* high for exactly one cycle.
REQ-015 wdp1..4 and wdm1..4 SHALL hold the last written values when the matching we_* is low.
REQ-016 rr_last SHALL update to the accepted requester on each transfer and otherwise hold.
REQ-017 Position: wr_pos_pxl SHALL equal pos_pxl at acceptance; pos_pxl toggles 0->1->0 after each pixel transfer. wr_mul_pos and pos_mul SHALL behave the same way.
REQ-018 mul_pair_done SHALL pulse in the same cycle as a we_mul with wr_mul_pos=1.
REQ-019 mul_pairs SHALL increment on each mul_pair_done and wrap 255->0.
REQ-020 stall=1: no transfer; in the cycle following a stalled cycle, we_pxl=we_mul=0; pos_*, rr_last and mul_pairs hold; a write already registered completes.
REQ-021 flush=1: no transfer; pos_pxl, pos_mul and rr_last clear to 0 next cycle; mul_pairs holds; flush has priority over stall and valid.
REQ-022 A write registered in the cycle flush rises SHALL still complete.

Reset
REQ-023 While rst is high, asynchronously: we_pxl, we_mul, wr_pos_pxl, wr_mul_pos, mul_pair_done = 0; wdp1..4, wdm1..4 = 0; mul_pairs = 0; pos_pxl = pos_mul = 0; rr_last = 0 (pixel).
REQ-024 Because rr_last resets to pixel, multiplier has priority on the first contention after reset.
REQ-025 pxl_ready and mul_ready SHALL be 0 while rst is high.
REQ-026 Reset asserted mid-transfer SHALL drop any pending write; no we_* pulse after release until a new transfer.

Verification
REQ-027 Single mul: mul_valid=1 with d=15,16,17,18 for 1 cycle, then d=150,160,170,180 -> we_mul pulses at pos 0 with 15..18, next cycle at pos 1 with 150..180; mul_pair_done=1 on the second; mul_pairs=1.
REQ-028 Contention: both valid continuously after reset for 4 cycles -> grants mul, pxl, mul, pxl; never two we_* in one cycle; wr_pos_pxl sequence 0,1.
REQ-029 Stall: mul_valid=1 and stall=1 for 3 cycles -> mul_ready=0 and we_mul=0 throughout; first write at pos 0 one cycle after stall drops.
REQ-030 Flush: after one pxl write (pos_pxl=1), flush=1 with pxl_valid=1 -> no accept that cycle; next pixel write uses wr_pos_pxl=0.
REQ-031 Wrap: 256 mul pairs -> mul_pairs returns to 0 and mul_pair_done pulses 256 times.
REQ-032 Async reset asserted between clock edges during a mul transfer -> all outputs 0 immediately; no we_mul after release.
